serial_add_ctrl: RTL and testbench

Bit-serial adder controller: sequences a single instance of the team's one-bit full adder (full_addr: in1, in2, cin -> sum, carry) over WIDTH-bit operands, one bit per clock, LSB first. Provides a start/done handshake and registered results. Used where area matters more than latency: one full adder plus shift registers instead of a WIDTH-bit ripple adder.

---
 rtl/serial_add_ctrl.sv | 111 +++++++++++
 tb/tb_serial_add_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder stepped over WIDTH-bit operands, LSB first,
// with a start/done handshake and registered sum/cout.

module full_addr (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = in1 ^ in2 ^ cin;
    assign carry = (in1 & in2) | (in1 & cin) | (in2 & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_res_next;

    full_addr u_fa (
        .in1   (r_a[0]),
        .in2   (r_b[0]),
        .cin   (r_carry),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // Shift-based form keeps the expression legal for WIDTH == 1 as well.
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_carry <= w_carry;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
                default: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_carry <= cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: WIDTH=8, 4 and 1 instances checked against plain
// arithmetic and the start-to-done latency rule.

module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] in1_8, in2_8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] in1_4, in2_4, sum4;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] in1_1, in2_1, sum1;

    int testsRun = 0;
    int testsFailed = 0;
    logic [8:0] last8;
    int cyc;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .in1(in1_8), .in2(in2_8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in1(in1_4), .in2(in2_4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in1(in1_1), .in2(in2_1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] expected;
        int n;
        expected = 9'(a) + 9'(b) + 9'(c);
        in1_8 = a; in2_8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        in1_8 = 8'($urandom); in2_8 = 8'($urandom); cin8 = 1'($urandom);
        n = 0;
        while (!done8 && n < 40) begin
            checkOutput("busy8", 64'(busy8), 64'd1);
            checkOutput("hold8", 64'({cout8, sum8}), 64'(last8));
            @(negedge clk);
            n++;
        end
        checkOutput("latency8", 64'(n), 64'd8);
        checkOutput("result8", 64'({cout8, sum8}), 64'(expected));
        checkOutput("busyAtDone8", 64'(busy8), 64'd0);
        last8 = expected;
    endtask

    task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] expected;
        int n;
        expected = 5'(a) + 5'(b) + 5'(c);
        in1_4 = a; in2_4 = b; cin4 = c; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        in1_4 = 4'($urandom); in2_4 = 4'($urandom);
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("latency4", 64'(n), 64'd4);
        checkOutput("result4", 64'({cout4, sum4}), 64'(expected));
    endtask

    task automatic applyStimulus1(input logic a, input logic b, input logic c);
        logic [1:0] expected;
        int n;
        expected = 2'(a) + 2'(b) + 2'(c);
        in1_1 = a; in2_1 = b; cin1 = c; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("busy1", 64'(busy1), 64'd1);
        n = 0;
        while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("latency1", 64'(n), 64'd1);
        checkOutput("result1", 64'({cout1, sum1}), 64'(expected));
    endtask

    initial begin
        start8 = 0; in1_8 = 0; in2_8 = 0; cin8 = 0;
        start4 = 0; in1_4 = 0; in2_4 = 0; cin4 = 0;
        start1 = 0; in1_1 = 0; in2_1 = 0; cin1 = 0;
        last8 = '0;
        rst_n = 1'b0;
        #1;
        checkOutput("rstBusy", 64'({busy8, busy4, busy1}), 64'd0);
        checkOutput("rstDone", 64'({done8, done4, done1}), 64'd0);
        checkOutput("rstSum8", 64'({cout8, sum8}), 64'd0);
        checkOutput("rstSum4", 64'({cout4, sum4}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic additions and full carry propagation.
        applyStimulus8(8'h3C, 8'h42, 1'b0);
        @(negedge clk);
        checkOutput("donePulse8", 64'(done8), 64'd0);
        checkOutput("idleBusy8", 64'(busy8), 64'd0);
        checkOutput("idleHold8", 64'({cout8, sum8}), 64'h07E);
        applyStimulus8(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        applyStimulus8(8'hA5, 8'h5A, 1'b1);
        applyStimulus8(8'h80, 8'h80, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // start held high through RUN: operands present at the DONE-cycle edge are taken.
        @(negedge clk);
        in1_8 = 8'h10; in2_8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        in1_8 = 8'h11; in2_8 = 8'h22;
        cyc = 0;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("b2bLat1", 64'(cyc), 64'd8);
        checkOutput("b2bRes1", 64'({cout8, sum8}), 64'h030);
        @(negedge clk);
        cyc = 1;
        start8 = 1'b0;
        checkOutput("b2bReload", 64'(busy8), 64'd1);
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("b2bLat2", 64'(cyc), 64'd9);
        checkOutput("b2bRes2", 64'({cout8, sum8}), 64'h033);
        last8 = 9'h033;

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        in1_8 = 8'hF0; in2_8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", 64'(busy8), 64'd0);
        checkOutput("midRstDone", 64'(done8), 64'd0);
        checkOutput("midRstSum", 64'({cout8, sum8}), 64'd0);
        #2 rst_n = 1'b1;
        last8 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("postRstDone", 64'(done8), 64'd0);
            checkOutput("postRstBusy", 64'(busy8), 64'd0);
        end
        checkOutput("postRstSum", 64'({cout8, sum8}), 64'd0);
        applyStimulus8(8'h12, 8'h34, 1'b1);

        // Exhaustive WIDTH=4, issued back to back through the DONE state.
        @(negedge clk);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    applyStimulus4(4'(a), 4'(b), 1'(c));

        // WIDTH=1.
        @(negedge clk);
        applyStimulus1(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus1(1'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
